// File: rtl/ps2_pkg.sv
// Shared PS/2 byte constants, FSM state type and status-byte classifier
// for the scancode filter.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_ST_ERR0    = 8'h00;
  localparam logic [7:0] PS2_ST_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_ST_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_ST_ACK     = 8'hFA;
  localparam logic [7:0] PS2_ST_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_ST_ERR1    = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_ST_ERR0)   || (b == PS2_ST_BAT_OK) ||
           (b == PS2_ST_ECHO)   || (b == PS2_ST_ACK)    ||
           (b == PS2_ST_RESEND) || (b == PS2_ST_ERR1);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Prefix timeout counter: counts cycles while a prefix is pending and flags
// the cycle in which the count reaches TIMEOUT_CYCLES-1.
module ps2_prefix_timer #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  assign expired = run && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scancode_filter.sv
// PS/2 scancode decoder: strips E0/F0 prefixes, reports key presses and
// protocol errors. Define PS2_REPEAT_FILTER_EN to suppress typematic repeats.
module ps2_scancode_filter
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_received_data,
  input  logic       ps2_received_data_strb,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_code_strb,
  output logic       protocol_error_strb
);

  ps2_state_t state, state_next;
  logic       make_event;
  logic       event_ext;
  logic       err_event;
  logic       emit_make;
  logic       expired;

  ps2_prefix_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (ps2_received_data_strb),
    .run    (state != ST_IDLE),
    .expired(expired)
  );

  always_comb begin
    state_next = state;
    make_event = 1'b0;
    event_ext  = 1'b0;
    err_event  = 1'b0;
    if (ps2_received_data_strb) begin
      case (state)
        ST_IDLE: begin
          if (ps2_received_data == PS2_EXT)      state_next = ST_EXT;
          else if (ps2_received_data == PS2_BRK) state_next = ST_BRK;
          else if (is_status(ps2_received_data)) err_event = 1'b1;
          else                                   make_event = 1'b1;
        end
        ST_EXT: begin
          if (ps2_received_data == PS2_BRK) begin
            state_next = ST_EXT_BRK;
          end else if (ps2_received_data == PS2_EXT) begin
            err_event = 1'b1;
          end else if (is_status(ps2_received_data)) begin
            err_event  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            make_event = 1'b1;
            event_ext  = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          // Break codes are consumed silently; only malformed bytes report.
          state_next = ST_IDLE;
          event_ext  = (state == ST_EXT_BRK);
          if (is_prefix(ps2_received_data) || is_status(ps2_received_data))
            err_event = 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (expired) begin
      state_next = ST_IDLE;
      err_event  = 1'b1;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [8:0] held;
  logic       held_valid;
  logic       held_match;
  logic       break_event;

  assign held_match  = (held == {event_ext, ps2_received_data});
  assign break_event = ps2_received_data_strb && !err_event &&
                       ((state == ST_BRK) || (state == ST_EXT_BRK));
  assign emit_make   = make_event && !(held_valid && held_match);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held       <= '0;
      held_valid <= 1'b0;
    end else if (emit_make) begin
      held       <= {event_ext, ps2_received_data};
      held_valid <= 1'b1;
    end else if (break_event && held_match) begin
      held_valid <= 1'b0;
    end
  end
`else
  assign emit_make = make_event;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= ST_IDLE;
      key_code            <= 8'h00;
      key_extended        <= 1'b0;
      key_code_strb       <= 1'b0;
      protocol_error_strb <= 1'b0;
    end else begin
      state               <= state_next;
      key_code_strb       <= emit_make;
      protocol_error_strb <= err_event;
      if (emit_make) begin
        key_code     <= ps2_received_data;
        key_extended <= event_ext;
      end
    end
  end

endmodule
